chacha_stream_ctrl: RTL and testbench
=====================================

# chacha_stream_ctrl

Keystream controller and XOR datapath wrapped around `chacha_block`:
- Builds the 512-bit ChaCha20 input state from a key, nonce and block counter, pulses the core, and captures the 512-bit keystream block on `done`.
- XORs that keystream, one 32-bit word per cycle, with a valid/ready data stream, so the block performs whole-message encrypt/decrypt.
- Requests a new block, with the counter incremented, every 16 words until the message's last word.

## Interface
Parameters:
- `WORDS_PER_BLOCK`, default 16: keystream words consumed per core block; fixed at 16 for ChaCha20 and not to be overridden.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset; the only clock and reset for this block.
- `cfg_load` in 1: one-cycle pulse that latches `key`, `nonce`, `ctr_init`; accepted only in IDLE.
- `key` in 256: key words k0..k7, k0 at [255:224], already little-endian word-converted by the host.
- `nonce` in 96: nonce words n0..n2, n0 at [95:64].
- `ctr_init` in 32: initial block counter.
- `busy` out 1: high in every state except IDLE.
- `ctr_wrap` out 1: sticky; set when the counter wraps from 0xFFFFFFFF to 0; cleared by `cfg_load` or reset.
- `in_valid`, `in_ready`, `in_data[31:0]`, `in_last`: input stream.
- `out_valid`, `out_ready`, `out_data[31:0]`, `out_last`: output stream.
- `core_start` out 1, `core_state` out 512: to `chacha_block` `start`/`state_in`.
- `core_done` in 1, `core_out` in 512: from `chacha_block` `done`/`state_out`.

## Operation
- Core state word i sits at [511-32i -: 32]:
  - w0..w3 = 0x61707865, 0x3320646e, 0x79622d32, 0x6b206574.
  - w4..w11 = k0..k7.
  - w12 = counter.
  - w13..w15 = n0..n2.
- `core_state` is driven combinationally from the latched key, nonce and counter registers.
- FSM states: IDLE, GEN, WAIT, STREAM.
  - IDLE → GEN on `cfg_load`: latch inputs, counter ← `ctr_init`, clear `ctr_wrap`.
  - GEN: assert `core_start` for exactly one cycle, then → WAIT.
  - WAIT: hold until `core_done`; on that cycle capture `core_out` into the 512-bit keystream register, reset word index to 0, then → STREAM.
  - STREAM: `in_ready` = !`out_valid` || `out_ready`.
    - On an input transfer (`in_valid` && `in_ready`): `out_data` ← `in_data` ^ ks word[idx], `out_last` ← `in_last`, `out_valid` ← 1, idx ← idx+1. Word 0 is ks[511:480].
    - If the transfer has `in_last`: → IDLE; unused keystream is discarded.
    - Else if idx was 15: counter ← counter+1 (mod 2^32; `ctr_wrap` set on wrap), then → GEN.
    - Without a new transfer, `out_valid` clears when `out_ready` is high.
- `in_ready` is 0 in IDLE, GEN and WAIT.
- An output word still pending in the output register when the FSM leaves STREAM keeps `out_valid` high until accepted; it is never lost or overwritten.
- `cfg_load` in any state other than IDLE is ignored. A new message needs a fresh `cfg_load` after `busy` falls.
- The block waits on `core_done`; it does not depend on the core's round count.
- `core_done` outside WAIT is ignored.

## Timing
- Reset values:
  - Outputs `busy`, `ctr_wrap`, `in_ready`, `out_valid`, `out_last`, `core_start` = 0.
  - `out_data` = 0; `core_state` reflects zeroed registers; constant words w0..w3 still read as above.
  - Internal state: FSM = IDLE, idx = 0, counter, key, nonce and keystream registers = 0.
- Reset mid-operation returns to IDLE immediately. The core must share `rst_n`.
- Cycle sequence from `cfg_load` at cycle 0:
  - `busy` = 1 and `core_start` = 1 in cycle 1.
  - With a 20-cycle core, `core_done` arrives in cycle 21.
  - `in_ready` is first high in cycle 22.
- Latency input→output: 1 cycle, registered.
- Throughput: 1 word/cycle within a block.
- Inter-block bubble: GEN + WAIT + core latency, 22 cycles for ChaCha20.

## Test plan
- RFC 8439 §2.3.2 block: key words 0x03020100..0x1f1e1d1c, nonce {0x09000000, 0x4a000000, 0x00000000}, ctr_init 1, in_data = 0 for 16 words → first out_data 0xe4e7f110, last word 0x4e3c50a2; `out_last` follows `in_last`.
- RFC 8439 §2.4.2: nonce {0, 0x4a000000, 0}, ctr 1, first in_data 0x6964614c ("Ladi") → out_data 0x9a352e6e. Full 114-byte message (29 words, last one padded) matches the RFC ciphertext across the block boundary; 2 core_start pulses total.
- Backpressure: random `out_ready` (50%) across 40 words → no drop or duplication of words, and `in_ready` never high while the output register is held.
- Counter wrap: ctr_init 0xFFFFFFFF, 20 words → second block's `core_state` w12 = 0; `ctr_wrap` = 1 until the next `cfg_load`.
- `cfg_load` pulsed during WAIT and STREAM → ignored, key and counter unchanged; `in_last` on word 5 → IDLE, `busy` = 0 one cycle later.
- `rst_n` low during WAIT → all outputs at reset values; a later `cfg_load` runs a clean block.

Source files
------------

// File: rtl/chacha_stream_ctrl.sv
// chacha_stream_ctrl: ChaCha20 keystream controller with a 32-bit valid/ready XOR datapath
module chacha_stream_ctrl #(
  parameter int WORDS_PER_BLOCK = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_load,
  input  logic [255:0] key,
  input  logic [95:0]  nonce,
  input  logic [31:0]  ctr_init,
  output logic         busy,
  output logic         ctr_wrap,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_data,
  output logic         out_last,
  output logic         core_start,
  output logic [511:0] core_state,
  input  logic         core_done,
  input  logic [511:0] core_out
);
  localparam int IW = $clog2(WORDS_PER_BLOCK);
  typedef enum logic [1:0] {IDLE, GEN, WAIT, STREAM} state_t;
  state_t         state, state_nx;
  logic [255:0]   key_r;
  logic [95:0]    nonce_r;
  logic [31:0]    ctr;
  logic [511:0]   ks;
  logic [IW-1:0]  idx;
  logic           xfer, blk_end;
  assign in_ready   = (state == STREAM) && (!out_valid || out_ready);
  assign xfer       = in_valid && in_ready;
  assign blk_end    = idx == IW'(WORDS_PER_BLOCK - 1);
  assign busy       = state != IDLE;
  assign core_start = state == GEN;
  assign core_state = {32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574, key_r, ctr, nonce_r};
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end
  // next-state: one start pulse per block, last word ends the message
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = cfg_load ? GEN : IDLE;
      GEN:     state_nx = WAIT;
      WAIT:    state_nx = core_done ? STREAM : WAIT;
      STREAM:  state_nx = !xfer ? STREAM : in_last ? IDLE : blk_end ? GEN : STREAM;
      default: state_nx = IDLE;
    endcase
  end
  // latched configuration and block counter; wrap flag is sticky until the next load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_r    <= '0;
      nonce_r  <= '0;
      ctr      <= '0;
      ctr_wrap <= 1'b0;
    end else if (state == IDLE && cfg_load) begin
      key_r    <= key;
      nonce_r  <= nonce;
      ctr      <= ctr_init;
      ctr_wrap <= 1'b0;
    end else if (xfer && !in_last && blk_end) begin
      ctr      <= ctr + 32'd1;
      if (&ctr) ctr_wrap <= 1'b1;
    end
  end
  // keystream block register shifts left so the current word always sits at the top
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ks  <= '0;
      idx <= '0;
    end else if (state == WAIT && core_done) begin
      ks  <= core_out;
      idx <= '0;
    end else if (xfer) begin
      ks  <= {ks[479:0], 32'h0};
      idx <= idx + 1'b1;
    end
  end
  // registered output word; a pending word survives state changes until accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data ^ ks[511:480];
      out_last  <= in_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_chacha_stream_ctrl.sv
// tb_chacha_stream_ctrl: directed bench with a behavioural 20-cycle ChaCha20 core
module tb_chacha_stream_ctrl;
  logic clk = 0, rst_n = 0, cfg_load = 0;
  logic [255:0] key = '0;
  logic [95:0] nonce = '0;
  logic [31:0] ctr_init = '0;
  logic busy, ctr_wrap, in_valid = 0, in_ready, in_last = 0, out_valid, out_ready = 1, out_last;
  logic [31:0] in_data = '0, out_data;
  logic core_start, core_done, spur = 0;
  logic [511:0] core_state, core_out;
  int checks = 0, errors = 0;

  localparam logic [255:0] K_RFC = {32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
                                    32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c};
  localparam logic [95:0] N_BLK = {32'h09000000, 32'h4a000000, 32'h00000000};
  localparam logic [95:0] N_ENC = {32'h00000000, 32'h4a000000, 32'h00000000};
  localparam logic [127:0] SIGMA = {32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574};

  chacha_stream_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .key(key), .nonce(nonce), .ctr_init(ctr_init),
    .busy(busy), .ctr_wrap(ctr_wrap), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .core_start(core_start), .core_state(core_state), .core_done(core_done),
    .core_out(core_out));

  always #5 clk = ~clk;

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [511:0] chacha(input logic [511:0] s);
    logic [31:0] x[16], x0[16];
    logic [511:0] r;
    int a, b, c, d;
    for (int i = 0; i < 16; i++) begin
      x[i] = s[511-32*i -: 32];
      x0[i] = x[i];
    end
    for (int rd = 0; rd < 10; rd++)
      for (int q = 0; q < 8; q++) begin
        a = q % 4;
        b = q < 4 ? a + 4 : 4 + (a + 1) % 4;
        c = q < 4 ? a + 8 : 8 + (a + 2) % 4;
        d = q < 4 ? a + 12 : 12 + (a + 3) % 4;
        x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 16);
        x[c] = x[c] + x[d]; x[b] = rotl(x[b] ^ x[c], 12);
        x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 8);
        x[c] = x[c] + x[d]; x[b] = rotl(x[b] ^ x[c], 7);
      end
    for (int i = 0; i < 16; i++) r[511-32*i -: 32] = x[i] + x0[i];
    return r;
  endfunction

  function automatic logic [511:0] mk(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c);
    return {SIGMA, k, c, n};
  endfunction

  // behavioural core: done 20 cycles after the start pulse, shares rst_n
  logic cb;
  logic [4:0] cnt;
  logic [511:0] res;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cb <= 0; cnt <= 0; res <= '0;
    end else if (core_start) begin
      cb <= 1; cnt <= 19; res <= chacha(core_state);
    end else if (cb) begin
      if (cnt == 0) cb <= 0;
      else cnt <= cnt - 1;
    end
  assign core_done = (cb && cnt == 0) || spur;
  assign core_out = res;

  // start pulse count and counter word seen by the core on each start
  int nstart = 0;
  logic [31:0] w12_seen = '0;
  always @(posedge clk)
    if (core_start) begin
      nstart <= nstart + 1;
      w12_seen <= core_state[127:96];
    end

  // output collector and backpressure monitor
  logic [32:0] q[$];
  int viol = 0;
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) q.push_back({out_last, out_data});
    if (rst_n && out_valid && !out_ready && in_ready) viol <= viol + 1;
  end

  logic [31:0] pt[64];
  bit rnd = 0;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c);
    key = k; nonce = n; ctr_init = c; cfg_load = 1;
    tick;
    cfg_load = 0;
  endtask

  task automatic send(input int n);
    int i = 0, cyc = 0;
    logic acc;
    out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    while (i < n && cyc < 3000) begin
      in_valid = 1; in_data = pt[i]; in_last = (i == n - 1);
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1; cyc++;
      if (acc) i++;
      if (i < n) out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    in_valid = 0; in_last = 0;
    chk("send_done", i, n);
  endtask

  task automatic drain;
    out_ready = 1;
    repeat (3) tick;
  endtask

  task automatic check_stream(input string tag, input int qb, input int n, input logic [255:0] k,
                              input logic [95:0] nn, input logic [31:0] c0);
    logic [511:0] blk;
    logic [31:0] c;
    chk({tag, "_count"}, q.size() - qb, n);
    for (int j = 0; j < n; j++)
      if (qb + j < q.size()) begin
        c = c0 + 32'(j / 16);
        blk = chacha(mk(k, nn, c));
        chk($sformatf("%s_w%0d", tag, j), q[qb+j], {j == n - 1, pt[j] ^ blk[511-32*(j%16) -: 32]});
      end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_wrap"}, ctr_wrap, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_start"}, core_start, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_core_state"}, core_state, {SIGMA, 384'h0});
  endtask

  initial begin
    string msg;
    int qb, sb, cyc;
    msg = "Ladies and Gentlemen of the class of '99: If I could offer you only one tip for the future, sunscreen would be it.";
    #12;
    chk_reset("rst");
    rst_n = 1;
    tick;
    spur = 1; tick; spur = 0; tick;
    chk("spur_done_idle", busy, 0);

    // RFC 8439 2.3.2 block with cycle timing
    for (int i = 0; i < 16; i++) pt[i] = 0;
    sb = nstart;
    load(K_RFC, N_BLK, 1);
    chk("c1_busy", busy, 1);
    chk("c1_start", core_start, 1);
    chk("c1_state", core_state, mk(K_RFC, N_BLK, 1));
    tick;
    chk("c2_start", core_start, 0);
    cyc = 2;
    while (!in_ready && cyc < 100) begin tick; cyc++; end
    chk("first_in_ready_cycle", cyc, 22);
    qb = q.size();
    send(16);
    drain;
    chk("blk_count", q.size() - qb, 16);
    if (q.size() - qb == 16) begin
      chk("blk_w0", q[qb], {1'b0, 32'he4e7f110});
      chk("blk_w15", q[qb+15], {1'b1, 32'h4e3c50a2});
    end
    chk("blk_starts", nstart - sb, 1);
    chk("blk_idle", busy, 0);

    // RFC 8439 2.4.2 encryption, 29 words across a block boundary
    for (int j = 0; j < 29; j++)
      for (int b = 0; b < 4; b++)
        pt[j][8*b +: 8] = (4 * j + b < msg.len()) ? msg[4*j+b] : 8'h00;
    sb = nstart;
    load(K_RFC, N_ENC, 1);
    qb = q.size();
    send(29);
    drain;
    if (q.size() > qb) chk("enc_w0", q[qb][31:0], 32'h9a352e6e);
    check_stream("enc", qb, 29, K_RFC, N_ENC, 1);
    chk("enc_starts", nstart - sb, 2);

    // random backpressure over 40 words
    for (int j = 0; j < 40; j++) pt[j] = $urandom;
    rnd = 1;
    load(~K_RFC, N_BLK, 32'd5);
    qb = q.size();
    send(40);
    rnd = 0;
    drain;
    check_stream("bp", qb, 40, ~K_RFC, N_BLK, 32'd5);
    chk("bp_no_ready_when_held", viol, 0);

    // counter wrap
    for (int j = 0; j < 20; j++) pt[j] = 32'h1000 + j;
    sb = nstart;
    load(K_RFC, N_ENC, 32'hffffffff);
    chk("wrap_clear0", ctr_wrap, 0);
    qb = q.size();
    send(20);
    drain;
    check_stream("wrap", qb, 20, K_RFC, N_ENC, 32'hffffffff);
    chk("wrap_starts", nstart - sb, 2);
    chk("wrap_w12", w12_seen, 0);
    chk("wrap_flag", ctr_wrap, 1);
    tick;
    chk("wrap_sticky", ctr_wrap, 1);

    // cfg_load ignored in WAIT and STREAM, in_last on word 5
    for (int j = 0; j < 6; j++) pt[j] = 32'hcafe0000 + j;
    load(~K_RFC, N_ENC, 32'd7);
    chk("wrap_cleared", ctr_wrap, 0);
    tick; tick;
    load(K_RFC, N_BLK, 32'd99);
    chk("ign_wait_state", core_state, mk(~K_RFC, N_ENC, 32'd7));
    cyc = 0;
    while (!in_ready && cyc < 100) begin tick; cyc++; end
    chk("ign_reach_stream", in_ready, 1);
    load(K_RFC, N_BLK, 32'd99);
    chk("ign_stream_state", core_state, mk(~K_RFC, N_ENC, 32'd7));
    chk("ign_stream_busy", busy, 1);
    qb = q.size();
    send(6);
    chk("last5_busy", busy, 0);
    out_ready = 0;
    tick; tick;
    chk("pending_valid", out_valid, 1);
    chk("pending_last", out_last, 1);
    drain;
    check_stream("ign", qb, 6, ~K_RFC, N_ENC, 32'd7);

    // reset during WAIT, then a clean block
    load(~K_RFC, N_BLK, 32'd3);
    repeat (5) tick;
    rst_n = 0;
    #1;
    chk_reset("mid");
    tick;
    rst_n = 1;
    tick;
    for (int i = 0; i < 16; i++) pt[i] = 0;
    load(K_RFC, N_BLK, 1);
    qb = q.size();
    send(16);
    drain;
    check_stream("post_rst", qb, 16, K_RFC, N_BLK, 1);
    if (q.size() > qb) chk("post_rst_w0", q[qb][31:0], 32'he4e7f110);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
